// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings, the FSM state type and the byte-lane geometry of a data word.
package dmem_responder_pkg;

  localparam int NB_LANE = 8;
  localparam int N_LANES = 4;
  localparam int NB_DATA = NB_LANE * N_LANES;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Unsigned widths only exist for loads; any other encoding is illegal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU-side data memory request/response bundle; the LSU is the master and
// the memory responder is the slave.
interface dmem_responder_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_WORD = 32
);
  logic [NB_ADDR-1:0] i_dmem_address;
  logic [NB_WORD-1:0] i_dmem_wr_data;
  logic               i_dmem_wr_enable;
  logic               i_dmem_rd_enable;
  logic [2:0]         i_dmem_funct3;
  logic               o_dmem_ready;
  logic [NB_WORD-1:0] o_dmem_rd_data;
  logic               o_dmem_done;
  logic               o_dmem_error;

  modport master (
    output i_dmem_address, i_dmem_wr_data, i_dmem_wr_enable, i_dmem_rd_enable, i_dmem_funct3,
    input  o_dmem_ready, o_dmem_rd_data, o_dmem_done, o_dmem_error
  );

  modport slave (
    input  i_dmem_address, i_dmem_wr_data, i_dmem_wr_enable, i_dmem_rd_enable, i_dmem_funct3,
    output o_dmem_ready, o_dmem_rd_data, o_dmem_done, o_dmem_error
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: builds the store lane mask
// and lane-replicated store word, and extracts/extends the load value.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]         funct3_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic [NB_DATA-1:0] rd_word_i,
  output logic [N_LANES-1:0] wr_mask_o,
  output logic [NB_DATA-1:0] wr_word_o,
  output logic [NB_DATA-1:0] ld_value_o,
  output logic               misalign_o
);

  logic [NB_LANE-1:0]   ld_byte;
  logic [2*NB_LANE-1:0] ld_half;

  assign ld_byte = rd_word_i[{addr_lo_i, 3'b000} +: NB_LANE];
  assign ld_half = rd_word_i[{addr_lo_i[1], 4'b0000} +: 2*NB_LANE];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    wr_mask_o  = '0;
    wr_word_o  = wr_data_i;
    ld_value_o = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        wr_mask_o  = 4'b0001 << addr_lo_i;
        wr_word_o  = {N_LANES{wr_data_i[NB_LANE-1:0]}};
        ld_value_o = (funct3_i == F3_B)
                   ? {{(NB_DATA-NB_LANE){ld_byte[NB_LANE-1]}}, ld_byte}
                   : {{(NB_DATA-NB_LANE){1'b0}}, ld_byte};
      end
      F3_H, F3_HU: begin
        wr_mask_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
        wr_word_o  = {2{wr_data_i[2*NB_LANE-1:0]}};
        ld_value_o = (funct3_i == F3_H)
                   ? {{(NB_DATA-2*NB_LANE){ld_half[2*NB_LANE-1]}}, ld_half}
                   : {{(NB_DATA-2*NB_LANE){1'b0}}, ld_half};
        misalign_o = addr_lo_i[0];
      end
      F3_W: begin
        wr_mask_o  = '1;
        ld_value_o = rd_word_i;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU data port: one outstanding request, optional
// wait states, byte/half/word access to a word-organised RAM, error flagging.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int NB_ADDR     = 32,
  parameter int NB_WORD     = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic            i_clock,
  input logic            i_reset,
  dmem_responder_if.slave dmem
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_t        state_q;
  logic [3:0]         cnt_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_WORD-1:0] wdata_q;
  logic [2:0]         f3_q;
  logic               store_q;
  logic [NB_WORD-1:0] rd_data_q;
  logic               done_q;
  logic               error_q;

  logic [NB_WORD-1:0] mem [DEPTH_WORDS];

  logic               req_valid;
  logic               go_resp;
  logic [NB_ADDR-1:0] acc_addr;
  logic [NB_WORD-1:0] acc_wdata;
  logic [2:0]         acc_f3;
  logic               acc_store;
  logic [IDX_W-1:0]   word_idx;
  logic               out_of_range;
  logic               access_err;
  logic [N_LANES-1:0] wr_mask;
  logic [NB_WORD-1:0] wr_word;
  logic [NB_WORD-1:0] ld_value;
  logic [NB_WORD-1:0] rd_word;
  logic               misalign;

  assign req_valid = dmem.i_dmem_rd_enable || dmem.i_dmem_wr_enable;

  // With no wait states the access happens on the accept edge itself, so the
  // live request is used there; otherwise the latched copy is.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_f3    = f3_q;
    acc_store = store_q;
    go_resp   = 1'b0;
    case (state_q)
      IDLE: begin
        acc_addr  = dmem.i_dmem_address;
        acc_wdata = dmem.i_dmem_wr_data;
        acc_f3    = dmem.i_dmem_funct3;
        acc_store = dmem.i_dmem_wr_enable;
        go_resp   = req_valid && (WAIT_STATES == 0);
      end
      WAIT:    go_resp = (cnt_q == '0);
      default: ;
    endcase
    go_resp = go_resp && !i_reset;
  end

  assign word_idx     = acc_addr[IDX_W+1:2];
  assign out_of_range = ({2'b00, acc_addr[NB_ADDR-1:2]} >= NB_ADDR'(DEPTH_WORDS));
  assign rd_word      = mem[word_idx];
  assign access_err   = misalign || out_of_range || !f3_legal(acc_f3, acc_store);

  dmem_lane_align u_align (
    .funct3_i   (acc_f3),
    .addr_lo_i  (acc_addr[1:0]),
    .wr_data_i  (acc_wdata),
    .rd_word_i  (rd_word),
    .wr_mask_o  (wr_mask),
    .wr_word_o  (wr_word),
    .ld_value_o (ld_value),
    .misalign_o (misalign)
  );

  // NOTE: the RAM has no reset branch; clearing every word would turn the
  // array into flops instead of a RAM macro, so contents are left as-is.
  always_ff @(posedge i_clock) begin
    if (go_resp && acc_store && !access_err) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (wr_mask[l]) mem[word_idx][l*NB_LANE +: NB_LANE] <= wr_word[l*NB_LANE +: NB_LANE];
      end
    end
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= dmem.i_dmem_address;
            wdata_q <= dmem.i_dmem_wr_data;
            f3_q    <= dmem.i_dmem_funct3;
            store_q <= dmem.i_dmem_wr_enable;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      if (go_resp) begin
        done_q  <= 1'b1;
        error_q <= access_err;
        if (access_err)      rd_data_q <= '0;
        else if (!acc_store) rd_data_q <= ld_value;
      end
    end
  end

  assign dmem.o_dmem_ready   = (state_q == IDLE) && !i_reset;
  assign dmem.o_dmem_rd_data = rd_data_q;
  assign dmem.o_dmem_done    = done_q;
  assign dmem.o_dmem_error   = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (0 and 3 wait states)
// driven by directed and random requests against a byte-array memory model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH0 = 1024;
  localparam int DEPTH3 = 256;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst3 = 1'b1;
  int          sel = 0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  f3 = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  exp_t        q0[$];
  exp_t        q3[$];
  logic [7:0]  mm [2][4096];
  logic [31:0] hold_rd [2];

  dmem_responder_if #(.NB_ADDR(32), .NB_WORD(32)) if0 ();
  dmem_responder_if #(.NB_ADDR(32), .NB_WORD(32)) if3 ();

  assign if0.i_dmem_address   = addr;
  assign if0.i_dmem_wr_data   = wdata;
  assign if0.i_dmem_funct3    = f3;
  assign if0.i_dmem_wr_enable = (sel == 0) && we;
  assign if0.i_dmem_rd_enable = (sel == 0) && re;
  assign if3.i_dmem_address   = addr;
  assign if3.i_dmem_wr_data   = wdata;
  assign if3.i_dmem_funct3    = f3;
  assign if3.i_dmem_wr_enable = (sel == 1) && we;
  assign if3.i_dmem_rd_enable = (sel == 1) && re;

  dmem_responder #(.NB_ADDR(32), .NB_WORD(32), .DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
    .i_clock (clk),
    .i_reset (rst0),
    .dmem    (if0)
  );

  dmem_responder #(.NB_ADDR(32), .NB_WORD(32), .DEPTH_WORDS(DEPTH3), .WAIT_STATES(3)) dut3 (
    .i_clock (clk),
    .i_reset (rst3),
    .dmem    (if3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int s);
    return (s == 0) ? DEPTH0 : DEPTH3;
  endfunction

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic logic ready_of(input int s);
    return (s == 0) ? if0.o_dmem_ready : if3.o_dmem_ready;
  endfunction

  // Reference behaviour: little-endian byte memory, rules applied directly.
  task automatic ref_model(input int s, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f, input int acc_cyc);
    exp_t        x;
    int          sz;
    bit          e;
    logic [31:0] v;
    sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e  = (f == 3'b011) || (f == 3'b110) || (f == 3'b111)
      || (w && (f == 3'b100 || f == 3'b101))
      || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00)
      || ((a >> 2) >= 32'(depth_of(s)));
    if (e) begin
      hold_rd[s] = '0;
    end else if (w) begin
      for (int i = 0; i < sz; i++) mm[s][int'(a[11:0]) + i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[s][int'(a[11:0]) + i];
      if (!f[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      hold_rd[s] = v;
    end
    x.err = e;
    x.rd  = hold_rd[s];
    x.cyc = acc_cyc + ws_of(s);
    if (s == 0) q0.push_back(x);
    else        q3.push_back(x);
  endtask

  task automatic issue(input int s, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f, input bit hold, input bit expect_resp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_of(s)) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 32'(ready_of(s)), 32'd1);
        return;
      end
    end
    sel = s; we = w; re = r; addr = a; wdata = d; f3 = f;
    @(posedge clk);
    #1;
    if (expect_resp) ref_model(s, w, a, d, f, cyc);
    if (hold) begin
      for (int k = 1; k <= ws_of(s) + 1; k++) begin
        @(negedge clk);
        check("ready_while_busy", 32'(ready_of(s)), 32'd0);
      end
      @(negedge clk);
      check("ready_after_resp", 32'(ready_of(s)), 32'd1);
    end
    we = 1'b0; re = 1'b0;
  endtask

  task automatic mon(input int s, input logic e, input logic [31:0] rd);
    exp_t x;
    int   qs;
    qs = (s == 0) ? q0.size() : q3.size();
    check(s == 0 ? "pending_resp_0" : "pending_resp_3", 32'(qs > 0), 32'd1);
    if (qs == 0) return;
    x = (s == 0) ? q0.pop_front() : q3.pop_front();
    check(s == 0 ? "error_0" : "error_3", 32'(e), 32'(x.err));
    check(s == 0 ? "rd_data_0" : "rd_data_3", rd, x.rd);
    check(s == 0 ? "done_cycle_0" : "done_cycle_3", 32'(cyc), 32'(x.cyc));
  endtask

  always @(negedge clk) begin
    if (if0.o_dmem_done) mon(0, if0.o_dmem_error, if0.o_dmem_rd_data);
    if (if3.o_dmem_done) mon(1, if3.o_dmem_error, if3.o_dmem_rd_data);
  end

  task automatic clear_region(input int s);
    for (int a = 0; a < 128; a += 4) issue(s, 1'b1, 1'b0, 32'(a), 32'd0, F3_W, 1'b0, 1'b1);
    issue(s, 1'b1, 1'b0, 32'(depth_of(s) * 4 - 4), 32'd0, F3_W, 1'b0, 1'b1);
  endtask

  task automatic random_phase(input int s, input int n);
    bit          w, r;
    logic [31:0] a;
    int          pick;
    for (int i = 0; i < n; i++) begin
      w    = 1'($urandom_range(0, 1));
      r    = w ? 1'($urandom_range(0, 1)) : 1'b1;
      pick = int'($urandom_range(0, 9));
      if (pick < 7)       a = 32'($urandom_range(0, 127));
      else if (pick == 7) a = 32'(depth_of(s) * 4) + 32'($urandom_range(0, 15));
      else if (pick == 8) a = $urandom;
      else                a = 32'(depth_of(s) * 4 - 4) + 32'($urandom_range(0, 3));
      issue(s, w, r, a, $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'b1);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      hold_rd[s] = '0;
      for (int b = 0; b < 4096; b++) mm[s][b] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("ready_in_reset_0", 32'(if0.o_dmem_ready), 32'd0);
    check("ready_in_reset_3", 32'(if3.o_dmem_ready), 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("reset_ready_0", 32'(if0.o_dmem_ready), 32'd1);
    check("reset_done_0", 32'(if0.o_dmem_done), 32'd0);
    check("reset_error_0", 32'(if0.o_dmem_error), 32'd0);
    check("reset_rd_data_0", if0.o_dmem_rd_data, 32'd0);
    check("reset_ready_3", 32'(if3.o_dmem_ready), 32'd1);
    check("reset_rd_data_3", if3.o_dmem_rd_data, 32'd0);

    clear_region(0);
    clear_region(1);

    // Zero wait states: word, byte and halfword access with extension.
    issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, F3_W, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, 1'b0, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h11, 32'h000000A5, F3_B, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h11, 32'h0, F3_B, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h11, 32'h0, F3_BU, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, 1'b0, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h80001234, F3_W, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h12, 32'h0, F3_H, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h12, 32'h0, F3_HU, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h13, 32'h0, F3_H, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, 1'b0, 1'b1);

    // Out-of-range store must not alias onto word 0; rd+wr together is a store.
    issue(0, 1'b1, 1'b0, 32'(DEPTH0 * 4), 32'h55AA55AA, F3_W, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h0, 32'h0, F3_W, 1'b0, 1'b1);
    issue(0, 1'b1, 1'b1, 32'h20, 32'h11223344, F3_W, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h20, 32'h0, F3_W, 1'b0, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h24, 32'h0, F3_HU, 1'b0, 1'b1);

    // Three wait states: ready timing with enables held through the busy window.
    issue(1, 1'b1, 1'b0, 32'h10, 32'h0BADF00D, F3_W, 1'b0, 1'b1);
    issue(1, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, 1'b1, 1'b1);

    // Reset while a store is still waiting: store dropped, no done pulse.
    issue(1, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, F3_W, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    check("ready_during_reset", 32'(if3.o_dmem_ready), 32'd0);
    rst3 = 1'b0;
    hold_rd[1] = '0;
    @(negedge clk);
    check("post_reset_ready", 32'(if3.o_dmem_ready), 32'd1);
    check("post_reset_done", 32'(if3.o_dmem_done), 32'd0);
    check("post_reset_rd_data", if3.o_dmem_rd_data, 32'd0);
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 1'b1, 32'h30, 32'h0, F3_W, 1'b0, 1'b1);

    random_phase(0, 150);
    random_phase(1, 150);

    repeat (20) @(negedge clk);
    check("scoreboard_drained_0", 32'(q0.size()), 32'd0);
    check("scoreboard_drained_3", 32'(q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
